// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO and a helper that sizes fill_count.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_SIZE  = 8;
  localparam int DEF_SIZE_BITS  = 3;

  // fill_count must represent 0..2**sb inclusive, hence one extra bit
  function automatic int fill_w(input int sb);
    return sb + 1;
  endfunction

  localparam int DEF_FILL_W = fill_w(DEF_SIZE_BITS);
endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one clocked write port, one asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // write port; contents are never reset, the control logic discards them
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO control: pointers, fill count, registered flags, sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is
// standard mode where q updates only on an accepted read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int FIFO_SIZE          = DEF_FIFO_SIZE,
  parameter int SIZE_BITS          = DEF_SIZE_BITS,
  parameter int ALMOST_FULL_LEVEL  = 6,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [SIZE_BITS:0]    fill_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = fill_w(SIZE_BITS);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_SIZE);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_LEVEL);

  logic [SIZE_BITS-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data, q_nxt;
  logic [CW-1:0]         fill_nxt;
  logic                  rd_acc, wr_acc;

  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(SIZE_BITS)) u_ram (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // acceptance, next fill level and next output word
  always_comb begin
    rd_acc     = read_enable && !fifo_empty;
    wr_acc     = write_enable && (!fifo_full || rd_acc);
    rd_ptr_nxt = rd_acc ? rd_ptr + SIZE_BITS'(1) : rd_ptr;
    fill_nxt   = fill_count;
    case ({wr_acc, rd_acc})
      2'b10:   fill_nxt = fill_count + CW'(1);
      2'b01:   fill_nxt = fill_count - CW'(1);
      default: fill_nxt = fill_count;
    endcase
`ifdef SYNC_FIFO_FWFT_EN
    // look ahead at the head after this edge; bypass the write when the
    // new head is the slot being written right now
    rd_addr = rd_ptr_nxt;
    q_nxt   = q;
    if (fill_nxt != '0)
      q_nxt = (wr_acc && rd_ptr_nxt == wr_ptr) ? data : rd_data;
`else
    rd_addr = rd_ptr;
    q_nxt   = rd_acc ? rd_data : q;
`endif
  end

  // state update; flags derive from the next fill level so they track fill_count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      q            <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + SIZE_BITS'(1);
      rd_ptr       <= rd_ptr_nxt;
      fill_count   <= fill_nxt;
      q            <= q_nxt;
      fifo_full    <= (fill_nxt == FULL_CNT);
      fifo_empty   <= (fill_nxt == '0);
      almost_full  <= (fill_nxt >= AF_LVL);
      almost_empty <= (fill_nxt <= AE_LVL);
      if (write_enable && !wr_acc) overflow  <= 1'b1;
      if (read_enable && !rd_acc)  underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized + directed bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;
  localparam int DW = 8, SZ = 4, SB = 2, AFL = 3, AEL = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data = '0;
  logic          write_enable = 1'b0, read_enable = 1'b0;
  logic [DW-1:0] q;
  logic          fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [SB:0]   fill_count;

  sync_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(SZ), .SIZE_BITS(SB),
              .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)) dut (
    .clock(clock), .reset(reset), .data(data),
    .write_enable(write_enable), .read_enable(read_enable), .q(q),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_count(fill_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int errs = 0, checks = 0;

  // reference model
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_q = '0;
  bit            m_ovf = 0, m_udf = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    int n = mq.size();
    chk({tag, ".q"},     int'(q), int'(m_q));
    chk({tag, ".fill"},  int'(fill_count), n);
    chk({tag, ".full"},  int'(fifo_full), int'(n == SZ));
    chk({tag, ".empty"}, int'(fifo_empty), int'(n == 0));
    chk({tag, ".af"},    int'(almost_full), int'(n >= AFL));
    chk({tag, ".ae"},    int'(almost_empty), int'(n <= AEL));
    chk({tag, ".ovf"},   int'(overflow), int'(m_ovf));
    chk({tag, ".udf"},   int'(underflow), int'(m_udf));
  endtask

  // one clock with given request; model applies the acceptance rules
  task automatic step(input string tag, input bit we, input bit re, input logic [DW-1:0] d);
    bit ra, wa;
    @(negedge clock);
    write_enable = we; read_enable = re; data = d;
    ra = re && mq.size() > 0;
    wa = we && (mq.size() < SZ || ra);
    @(posedge clock); #1;
    if (ra) begin
`ifdef SYNC_FIFO_FWFT_EN
      void'(mq.pop_front());
`else
      m_q = mq.pop_front();
`endif
    end
    if (wa) mq.push_back(d);
    if (we && !wa) m_ovf = 1;
    if (re && !ra) m_udf = 1;
`ifdef SYNC_FIFO_FWFT_EN
    if (mq.size() > 0) m_q = mq[0];
`endif
    chk_all(tag);
  endtask

  // asynchronous reset placed mid low-phase, checked before any clock edge
  task automatic do_reset(input string tag);
    @(negedge clock); #2;
    reset = 1'b0;
    mq.delete(); m_q = '0; m_ovf = 0; m_udf = 0;
    #1 chk_all(tag);
    write_enable = 0; read_enable = 0;
    @(negedge clock); reset = 1'b1;
  endtask

  initial begin
    #12 chk_all("rst0");
    @(negedge clock); reset = 1'b1;

    // read on empty after reset
    step("udf", 0, 1, 8'h00);
    do_reset("rst1");

    // fill, drain in order
    step("w11", 1, 0, 8'h11); step("w22", 1, 0, 8'h22);
    step("w33", 1, 0, 8'h33); step("w44", 1, 0, 8'h44);
    for (int i = 0; i < 4; i++) step("rd", 0, 1, 8'h00);

    // overflow while full, contents untouched
    step("w11b", 1, 0, 8'h11); step("w22b", 1, 0, 8'h22);
    step("w33b", 1, 0, 8'h33); step("w44b", 1, 0, 8'h44);
    step("w55", 1, 0, 8'h55);
    for (int i = 0; i < 4; i++) step("rdo", 0, 1, 8'h00);
    do_reset("rst2");

    // simultaneous read/write when full
    for (int i = 0; i < 4; i++) step("wf", 1, 0, 8'h11 * (i + 1));
    step("rw66", 1, 1, 8'h66);
    for (int i = 0; i < 4; i++) step("rd66", 0, 1, 8'h00);

    // simultaneous read/write when empty: write wins, underflow set
    step("rwe", 1, 1, 8'h99);
    step("rwe_rd", 0, 1, 8'h00);
    do_reset("rst3");

    // interleaved, wrapping pointers
    step("iA0", 1, 0, 8'hA0);
    for (int i = 1; i < 6; i++) step("iAx", 1, 1, 8'hA0 + 8'(i));
    step("iend", 0, 1, 8'h00);

    // reset mid-burst at fill 2, then resume
    step("mb0", 1, 0, 8'h01); step("mb1", 1, 0, 8'h02);
    do_reset("rst_mid");
    step("w77", 1, 0, 8'h77);
    step("idle", 0, 0, 8'h00);
    step("r77", 0, 1, 8'h00);

    // random traffic, occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rst_rnd");
      else step("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
